// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI RAM arbiter: FSM states, operation encoding,
// and an index-width helper that never returns zero.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Width of an index into n items, at least one bit so a single requester still has a port.
  function automatic int spi_clog2(input int n);
    int r;
    r = 1;
    while ((32'sd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational rotate-priority encoder: first asserted request at or after ptr, wrapping.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = spi_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  logic [NUM_REQ-1:0] rot_s;
  logic [IW-1:0]      off_s;
  logic [IW:0]        sum_s;

  // Rotate so ptr lands on bit 0, find the lowest set offset, then map back to an index.
  always_comb begin
    rot_s = NUM_REQ'({req, req} >> ptr);
    valid = |rot_s;
    off_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) off_s = IW'(k);
      else          off_s = off_s;
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (IW+1)'(NUM_REQ)) idx = IW'(sum_s - (IW+1)'(NUM_REQ));
    else                           idx = sum_s[IW-1:0];
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one spi_ram_controller among NUM_REQ requesters;
// one transfer in flight, start strobe held until the controller goes busy.
module spi_ram_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int ADDR_BITS        = 16,
  parameter int DATA_WIDTH_BYTES = 4,
  localparam int DW              = 8 * DATA_WIDTH_BYTES,
  localparam int IW              = spi_clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_read,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [DW-1:0]                rdata,
  output logic [IW-1:0]                grant_id,
  output logic                         idle,
  output logic [ADDR_BITS-1:0]         ctrl_addr,
  output logic [DW-1:0]                ctrl_wdata,
  output logic                         ctrl_start_read,
  output logic                         ctrl_start_write,
  input  logic [DW-1:0]                ctrl_rdata,
  input  logic                         ctrl_busy
);

  arb_state_t             state_r, state_nx_s;
  arb_op_t                op_r, op_sel_s;
  logic [IW-1:0]          rr_ptr_r, ptr_nx_s, grant_id_r;
  logic [IW-1:0]          pick_idx_s;
  logic                   pick_valid_s;
  logic [ADDR_BITS-1:0]   ctrl_addr_r, addr_sel_s;
  logic [DW-1:0]          ctrl_wdata_r, wdata_sel_s, rdata_r;
  logic                   start_rd_r, start_wr_r, start_rd_nx_s, start_wr_nx_s;
  logic [NUM_REQ-1:0]     ack_r, ack_nx_s;
  logic                   idle_r, grant_ld_s, rdata_ld_s;

  spi_arb_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_read | req_write),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_valid_s && !ctrl_busy) state_nx_s = S_ISSUE;
        else                            state_nx_s = S_IDLE;
      end
      S_ISSUE: begin
        if (ctrl_busy) state_nx_s = S_WAIT;
        else           state_nx_s = S_ISSUE;
      end
      S_WAIT: begin
        if (!ctrl_busy) state_nx_s = S_DONE;
        else            state_nx_s = S_WAIT;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs; both-high requests become writes
  always_comb begin
    op_sel_s      = req_write[pick_idx_s] ? OP_WRITE : OP_READ;
    addr_sel_s    = req_addr[int'(pick_idx_s)*ADDR_BITS +: ADDR_BITS];
    wdata_sel_s   = req_wdata[int'(pick_idx_s)*DW +: DW];
    grant_ld_s    = 1'b0;
    start_rd_nx_s = 1'b0;
    start_wr_nx_s = 1'b0;
    ack_nx_s      = '0;
    rdata_ld_s    = 1'b0;
    if (pick_idx_s == IW'(NUM_REQ - 1)) ptr_nx_s = '0;
    else                                ptr_nx_s = pick_idx_s + IW'(1'b1);
    case (state_r)
      S_IDLE: begin
        if (pick_valid_s && !ctrl_busy) begin
          grant_ld_s    = 1'b1;
          start_wr_nx_s = (op_sel_s == OP_WRITE);
          start_rd_nx_s = (op_sel_s == OP_READ);
        end else begin
          grant_ld_s    = 1'b0;
        end
      end
      S_ISSUE: begin
        start_rd_nx_s = start_rd_r & ~ctrl_busy;
        start_wr_nx_s = start_wr_r & ~ctrl_busy;
      end
      S_WAIT: begin
        if (!ctrl_busy) begin
          ack_nx_s   = NUM_REQ'(1'b1) << grant_id_r;
          rdata_ld_s = (op_r == OP_READ);
        end else begin
          ack_nx_s   = '0;
          rdata_ld_s = 1'b0;
        end
      end
      S_DONE:  ack_nx_s = '0;
      default: ack_nx_s = '0;
    endcase
  end

  // Grant, controller-side and requester-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r     <= '0;
      grant_id_r   <= '0;
      op_r         <= OP_READ;
      ctrl_addr_r  <= '0;
      ctrl_wdata_r <= '0;
      start_rd_r   <= 1'b0;
      start_wr_r   <= 1'b0;
      ack_r        <= '0;
      rdata_r      <= '0;
      idle_r       <= 1'b1;
    end else begin
      if (grant_ld_s) begin
        rr_ptr_r     <= ptr_nx_s;
        grant_id_r   <= pick_idx_s;
        op_r         <= op_sel_s;
        ctrl_addr_r  <= addr_sel_s;
        ctrl_wdata_r <= wdata_sel_s;
      end
      start_rd_r <= start_rd_nx_s;
      start_wr_r <= start_wr_nx_s;
      ack_r      <= ack_nx_s;
      idle_r     <= (state_nx_s == S_IDLE);
      if (rdata_ld_s) rdata_r <= ctrl_rdata;
    end
  end

  assign req_ack          = ack_r;
  assign rdata            = rdata_r;
  assign grant_id         = grant_id_r;
  assign idle             = idle_r;
  assign ctrl_addr        = ctrl_addr_r;
  assign ctrl_wdata       = ctrl_wdata_r;
  assign ctrl_start_read  = start_rd_r;
  assign ctrl_start_write = start_wr_r;

endmodule
